// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode with register file, WB bypass,
// in-stage branch resolution, hazard detection and the ID/EX register.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_valid,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  output logic        is_flush,
  output logic        is_stall,
  output logic [31:0] branch_target,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic        ex_alu_src_pc,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic [2:0]  ex_funct3
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [2:0]  funct3;
  } idex_t;

  function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  alu_fn = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  logic [31:0] rf_q [32];
  idex_t       idex_d, idex_q;

  opcode_e     opcode;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        known, use1, use2, br_op, taken;
  logic [31:0] target;
  idex_t       dec;
  logic        hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic        load_use, br_hazard, valid_known;

  assign opcode = opcode_e'(instr[6:0]);
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // register file with reset clear; x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // combinational reads; same-cycle WB write is bypassed in
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_f != '0) rs1_data = (wb_we && wb_rd == rs1_f) ? wb_data : rf_q[rs1_f];
    if (rs2_f != '0) rs2_data = (wb_we && wb_rd == rs2_f) ? wb_data : rf_q[rs2_f];
  end

  // opcode decode, immediate/ALU setup and branch resolution
  always_comb begin
    known  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    br_op  = 1'b0;
    taken  = 1'b0;
    target = '0;
    dec    = '0;
    case (opcode)
      OP_R: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_fn(f3, instr[30], 1'b1);
      end
      OP_IMM: begin
        known = 1'b1; use1 = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
        dec.alu_op      = alu_fn(f3, instr[30], 1'b0);
      end
      OP_LOAD: begin
        known = 1'b1; use1 = 1'b1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src_imm = 1'b1; dec.imm = imm_i;
      end
      OP_STORE: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src_imm = 1'b1; dec.imm = imm_s;
      end
      OP_BRANCH: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1; br_op = 1'b1;
        dec.imm = imm_b;
        target  = pc + imm_b;
        case (f3)
          3'b000:  taken = (rs1_data == rs2_data);
          3'b001:  taken = (rs1_data != rs2_data);
          3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  taken = (rs1_data <  rs2_data);
          3'b111:  taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        known = 1'b1; taken = 1'b1;
        target = pc + imm_j;
        dec.reg_write = 1'b1; dec.alu_src_pc = 1'b1;
        dec.alu_src_imm = 1'b1; dec.imm = 32'd4;
      end
      OP_JALR: begin
        known = 1'b1; use1 = 1'b1; br_op = 1'b1; taken = 1'b1;
        target = (rs1_data + imm_i) & ~32'd1;
        dec.reg_write = 1'b1; dec.alu_src_pc = 1'b1;
        dec.alu_src_imm = 1'b1; dec.imm = 32'd4;
      end
      OP_LUI: begin
        known = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
        dec.imm = imm_u; dec.alu_op = ALU_PASS_B;
      end
      OP_AUIPC: begin
        known = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1;
        dec.imm = imm_u;
      end
      default: known = 1'b0;
    endcase
    dec.valid    = 1'b1;
    dec.pc       = pc;
    dec.funct3   = f3;
    dec.rs1      = use1 ? rs1_f : '0;
    dec.rs2      = use2 ? rs2_f : '0;
    dec.rs1_data = use1 ? rs1_data : '0;
    dec.rs2_data = use2 ? rs2_data : '0;
    dec.rd       = dec.reg_write ? rd_f : '0;
  end

  // hazards, redirect and next ID/EX contents; x0 never matches
  always_comb begin
    hit1_ex     = use1 && rs1_f != '0 && rs1_f == idex_q.rd;
    hit2_ex     = use2 && rs2_f != '0 && rs2_f == idex_q.rd;
    hit1_mem    = use1 && rs1_f != '0 && rs1_f == mem_rd;
    hit2_mem    = use2 && rs2_f != '0 && rs2_f == mem_rd;
    load_use    = idex_q.valid && idex_q.mem_read && (hit1_ex || hit2_ex);
    br_hazard   = br_op && ((idex_q.reg_write && (hit1_ex || hit2_ex)) ||
                            (mem_reg_write && (hit1_mem || hit2_mem)));
    valid_known = is_valid && known && !reset;
    is_stall    = valid_known && (load_use || br_hazard);
    is_flush    = valid_known && taken && !is_stall;
    branch_target = is_flush ? target : '0;
    idex_d      = (valid_known && !is_stall) ? dec : '0;
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign ex_valid       = idex_q.valid;
  assign ex_pc          = idex_q.pc;
  assign ex_rs1_data    = idex_q.rs1_data;
  assign ex_rs2_data    = idex_q.rs2_data;
  assign ex_imm         = idex_q.imm;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_rd          = idex_q.rd;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_alu_src_imm = idex_q.alu_src_imm;
  assign ex_alu_src_pc  = idex_q.alu_src_pc;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_funct3      = idex_q.funct3;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: downstream pipeline signals are driven by hand.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, is_valid, wb_we, mem_reg_write;
  logic [31:0] pc, instr, wb_data;
  logic [4:0]  wb_rd, mem_rd;
  logic        is_flush, is_stall, ex_valid;
  logic [31:0] branch_target, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .is_valid(is_valid), .pc(pc), .instr(instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .is_flush(is_flush), .is_stall(is_stall), .branch_target(branch_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_alu_src_pc(ex_alu_src_pc), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic v, input logic [31:0] p, input logic [31:0] i);
    is_valid = v;
    pc       = p;
    instr    = i;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mem_reg_write = 1'b0; mem_rd = '0;
    present(1'b1, 32'h0, 32'h008000EF);             // jal x1,+8 held during reset
    #1;
    chk("rst_flush", is_flush, 0);
    chk("rst_stall", is_stall, 0);
    chk("rst_target", branch_target, 0);
    tick();
    tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_reg_write", ex_reg_write, 0);

    // addi x1,x0,5
    reset = 1'b0;
    present(1'b1, 32'h4, 32'h00500093);
    tick();
    chk("addi_valid", ex_valid, 1);
    chk("addi_rd", ex_rd, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_op", ex_alu_op, 0);
    chk("addi_src_imm", ex_alu_src_imm, 1);
    chk("addi_reg_write", ex_reg_write, 1);
    chk("addi_pc", ex_pc, 32'h4);

    // lw x2,0(x1) then add x3,x2,x2
    present(1'b1, 32'h8, 32'h0000A103);
    #1 chk("lw_no_stall", is_stall, 0);
    tick();
    chk("lw_mem_read", ex_mem_read, 1);
    chk("lw_rd", ex_rd, 2);
    chk("lw_funct3", ex_funct3, 2);
    present(1'b1, 32'hC, 32'h002101B3);
    #1 chk("lu_stall", is_stall, 1);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_released", is_stall, 0);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_rs1", ex_rs1, 2);
    chk("add_rs2", ex_rs2, 2);
    chk("add_rd", ex_rd, 3);
    chk("add_src_imm", ex_alu_src_imm, 0);

    // WB writes x1=7, x2=7
    present(1'b0, 32'h10, 32'h00000013);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
    tick();
    wb_rd = 5'd2;
    tick();
    wb_we = 1'b0;

    // beq x1,x2,+16 at 0x20 : taken
    present(1'b1, 32'h20, 32'h00208863);
    #1;
    chk("beq_flush", is_flush, 1);
    chk("beq_target", branch_target, 32'h30);
    chk("beq_stall", is_stall, 0);
    tick();
    chk("beq_ex_valid", ex_valid, 1);
    chk("beq_reg_write", ex_reg_write, 0);
    chk("beq_mem_write", ex_mem_write, 0);
    present(1'b0, 32'h30, 32'h00000013);
    #1 chk("nop_flush", is_flush, 0);
    chk("nop_target", branch_target, 0);
    tick();
    chk("nop_bubble", ex_valid, 0);

    // bne x1,x2,+16 at 0x24 : not taken
    present(1'b1, 32'h24, 32'h00209863);
    #1;
    chk("bne_flush", is_flush, 0);
    chk("bne_stall", is_stall, 0);
    chk("bne_target", branch_target, 0);
    tick();
    chk("bne_ex_valid", ex_valid, 1);
    chk("bne_ex_pc", ex_pc, 32'h24);

    // bne at 0x28 while WB writes x2=8 the same cycle : taken via bypass
    present(1'b1, 32'h28, 32'h00209863);
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd8;
    #1;
    chk("byp_flush", is_flush, 1);
    chk("byp_target", branch_target, 32'h38);
    tick();
    chk("byp_rs2_data", ex_rs2_data, 32'd8);

    // x5 = 0x103, then jalr x1,0(x5) at 0x40
    present(1'b0, 32'h2C, 32'h00000013);
    wb_rd = 5'd5; wb_data = 32'h103;
    tick();
    wb_we = 1'b0;
    present(1'b1, 32'h40, 32'h000280E7);
    #1;
    chk("jalr_flush", is_flush, 1);
    chk("jalr_target", branch_target, 32'h102);
    tick();
    chk("jalr_src_pc", ex_alu_src_pc, 1);
    chk("jalr_imm", ex_imm, 4);
    chk("jalr_rd", ex_rd, 1);
    chk("jalr_reg_write", ex_reg_write, 1);
    chk("jalr_rs1_data", ex_rs1_data, 32'h103);

    // addi x6,x0,1 then beq x6,x0,+8 : operand hazard for 2 cycles
    present(1'b1, 32'h50, 32'h00100313);
    tick();
    present(1'b1, 32'h54, 32'h00030463);
    #1;
    chk("bhz_stall_ex", is_stall, 1);
    chk("bhz_flush_ex", is_flush, 0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd6;
    #1;
    chk("bhz_bubble", ex_valid, 0);
    chk("bhz_stall_mem", is_stall, 1);
    tick();
    mem_reg_write = 1'b0; mem_rd = '0;
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'd1;
    #1;
    chk("bhz_stall_wb", is_stall, 0);
    chk("bhz_flush_wb", is_flush, 0);
    tick();
    wb_we = 1'b0;
    chk("bhz_ex_valid", ex_valid, 1);
    chk("bhz_ex_pc", ex_pc, 32'h54);

    // add x7,x0,x0 while WB targets x0
    present(1'b1, 32'h58, 32'h000003B3);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0;
    chk("x0_rs1_data", ex_rs1_data, 0);
    chk("x0_rs2_data", ex_rs2_data, 0);
    chk("x0_rd", ex_rd, 7);

    // unknown opcode
    present(1'b1, 32'h5C, 32'hFFFFFFFF);
    #1;
    chk("unk_stall", is_stall, 0);
    chk("unk_flush", is_flush, 0);
    tick();
    chk("unk_bubble", ex_valid, 0);
    chk("unk_reg_write", ex_reg_write, 0);

    // lw x9,0(x0) then add x10,x9,x0 ; reset asserted mid-stall
    present(1'b1, 32'h60, 32'h00002483);
    tick();
    present(1'b1, 32'h64, 32'h00048533);
    #1 chk("rst2_pre_stall", is_stall, 1);
    reset = 1'b1;
    #1;
    chk("rst2_stall", is_stall, 0);
    chk("rst2_flush", is_flush, 0);
    tick();
    chk("rst2_ex_valid", ex_valid, 0);
    chk("rst2_mem_read", ex_mem_read, 0);
    reset = 1'b0;

    // addi x11,x1,0 : x1 cleared by reset
    present(1'b1, 32'h68, 32'h00008593);
    tick();
    chk("clr_rs1_data", ex_rs1_data, 0);
    chk("clr_rd", ex_rd, 11);

    // sub x12,x1,x2
    present(1'b1, 32'h6C, 32'h40208633);
    tick();
    chk("sub_op", ex_alu_op, 1);

    // lui x13,0x12345
    present(1'b1, 32'h70, 32'h123456B7);
    tick();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_op", ex_alu_op, 10);
    chk("lui_src_pc", ex_alu_src_pc, 0);

    // sw x2,4(x1)
    present(1'b1, 32'h74, 32'h0020A223);
    tick();
    chk("sw_mem_write", ex_mem_write, 1);
    chk("sw_reg_write", ex_reg_write, 0);
    chk("sw_imm", ex_imm, 4);
    chk("sw_funct3", ex_funct3, 2);

    // addi x1,x0,-1
    present(1'b1, 32'h78, 32'hFFF00093);
    tick();
    chk("neg_imm", ex_imm, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
